// File: rtl/bus_pkg.sv
// Shared definitions for the 128-bit qword cache-line bus. The data cache and the
// instruction cache fill paths use this package too.
package bus_pkg;

    localparam int BUS_DATA_WIDTH_SHIFT = 4;
    localparam int BUS_DATA_WIDTH       = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DROP = 2'd3
    } resp_state_t;

endpackage

// File: rtl/qword_sram.sv
// Single-port synchronous qword RAM. Reads return the old contents (read-first).
// The RAM has no reset, so its contents survive a reset of the responder.
module qword_sram
    import bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = BUS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/qword_bus_responder.sv
// Memory-side responder for the qword cache-line bus: a wait-state FSM in front of qword_sram.
// Optional feature: define MEM_RESP_STATS_EN to enable the read/write acknowledge counters.
module qword_bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [ADDR_WIDTH-1:0]     bus_addr_i,
    input  logic                      bus_valid_i,
    input  logic                      bus_we_i,
    input  logic [BUS_DATA_WIDTH-1:0] bus_data_i,
    output logic                      bus_valid_o,
    output logic [BUS_DATA_WIDTH-1:0] bus_data_o,
    output logic [31:0]               stat_rd_o,
    output logic [31:0]               stat_wr_o
);

    localparam int CNT_W = 4;

    resp_state_t               state;
    resp_state_t               next_state;
    logic [CNT_W-1:0]          wait_cnt;
    logic [DEPTH_LOG2-1:0]     lat_index;
    logic                      lat_we;
    logic [BUS_DATA_WIDTH-1:0] lat_data;
    logic [BUS_DATA_WIDTH-1:0] sram_rdata;
    logic [BUS_DATA_WIDTH-1:0] data_hold;
    logic                      accept;
    logic                      enter_ack;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // WAIT is always visited, even with zero wait states, so the RAM only ever sees the latched request
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus_valid_i) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = DROP;
            end
            DROP: begin
                if (!bus_valid_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign enter_ack = (state == WAIT) && (wait_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt  <= '0;
            lat_index <= '0;
            lat_we    <= 1'b0;
            lat_data  <= '0;
        end else if (accept) begin
            wait_cnt  <= CNT_W'(WAIT_STATES);
            lat_index <= bus_addr_i[DEPTH_LOG2-1:0];
            lat_we    <= bus_we_i;
            lat_data  <= bus_data_i;
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_alias
            logic unused_alias_bits;
            assign unused_alias_bits = ^bus_addr_i[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    qword_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (BUS_DATA_WIDTH)
    ) u_sram (
        .clk   (clk_i),
        .we    (enter_ack && lat_we),
        .addr  (lat_index),
        .wdata (lat_data),
        .rdata (sram_rdata)
    );

    // The RAM output register holds the read result during ACK; it is copied here so it stays put afterwards
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_hold <= '0;
        end else if ((state == ACK) && !lat_we) begin
            data_hold <= sram_rdata;
        end
    end

    assign bus_valid_o = (state == ACK);
    assign bus_data_o  = ((state == ACK) && !lat_we) ? sram_rdata : data_hold;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (enter_ack) begin
            if (lat_we) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end

    assign stat_rd_o = rd_count;
    assign stat_wr_o = wr_count;
`else
    assign stat_rd_o = 32'd0;
    assign stat_wr_o = 32'd0;
`endif

endmodule

// File: tb/tb_qword_bus_responder.sv
// Self-checking bench for qword_bus_responder: directed scenarios plus random traffic checked
// against a simple memory/latency model. Honours MEM_RESP_STATS_EN for the counter expectations.
module tb_qword_bus_responder;

    localparam int TB_WS = 2;
    localparam int DEPTH = 1024;
`ifdef MEM_RESP_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bus_valid, bus_we;
    logic [15:0]  bus_addr;
    logic [127:0] bus_data;
    logic         ack;
    logic [127:0] rdata;
    logic [31:0]  stat_rd, stat_wr;

    logic         f_valid, f_we;
    logic [15:0]  f_addr;
    logic [127:0] f_data;
    logic         f_ack;
    logic [127:0] f_rdata;
    logic [31:0]  f_srd, f_swr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [127:0] model_mem [int];
    logic [127:0] model_last_rd;
    int           model_rd, model_wr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qword_bus_responder #(.ADDR_WIDTH(16), .DEPTH_LOG2(10), .WAIT_STATES(TB_WS)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus_addr_i(bus_addr), .bus_valid_i(bus_valid),
        .bus_we_i(bus_we), .bus_data_i(bus_data), .bus_valid_o(ack), .bus_data_o(rdata),
        .stat_rd_o(stat_rd), .stat_wr_o(stat_wr)
    );

    qword_bus_responder #(.ADDR_WIDTH(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_fast (
        .clk_i(clk), .rst_n_i(rst_n), .bus_addr_i(f_addr), .bus_valid_i(f_valid),
        .bus_we_i(f_we), .bus_data_i(f_data), .bus_valid_o(f_ack), .bus_data_o(f_rdata),
        .stat_rd_o(f_srd), .stat_wr_o(f_swr)
    );

    function automatic logic [31:0] exp_stat(input int n);
        return STATS_ON ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_apply(input logic we, input logic [15:0] addr, input logic [127:0] data);
        if (we) begin
            model_mem[int'(addr[9:0])] = data;
            model_wr++;
        end else begin
            model_last_rd = model_mem[int'(addr[9:0])];
            model_rd++;
        end
    endtask

    task automatic model_reset();
        model_rd = 0;
        model_wr = 0;
        model_last_rd = '0;
    endtask

    // Issues one request at a negedge; returns cycles from accept to ack, ack pulse count and ack data.
    task automatic bus_txn(input logic we, input logic [15:0] addr, input logic [127:0] data,
                           input int hold, output int delay, output int pulses, output logic [127:0] got);
        bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_data = data;
        delay = -1; pulses = 0; got = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) begin
                delay = c; pulses = 1; got = rdata;
                break;
            end
            bus_addr = 16'($urandom); bus_data = rand128(); bus_we = 1'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (ack) pulses++;
        end
        bus_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_valid = 0; bus_we = 0; bus_addr = '0; bus_data = '0;
        f_valid = 0; f_we = 0; f_addr = '0; f_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack got=%b want=0", ack); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_data got=%h want=0", rdata); end
        n_checks++; if (stat_rd !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_stat_rd got=%0d want=0", stat_rd); end
        n_checks++; if (stat_wr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_stat_wr got=%0d want=0", stat_wr); end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int d, p; logic [127:0] r; logic [127:0] v;
        v = 128'h0123456789ABCDEF0123456789ABCDEF;
        bus_txn(1'b1, 16'h0005, v, 0, d, p, r);
        model_apply(1'b1, 16'h0005, v);
        n_checks++; if (d !== TB_WS + 2) begin n_fail++; $display("[TB] FAIL wr_latency got=%0d want=%0d", d, TB_WS + 2); end
        n_checks++; if (p !== 1) begin n_fail++; $display("[TB] FAIL wr_pulse got=%0d want=1", p); end
        n_checks++; if (r !== model_last_rd) begin n_fail++; $display("[TB] FAIL wr_data_held got=%h want=%h", r, model_last_rd); end
        bus_txn(1'b0, 16'h0005, rand128(), 0, d, p, r);
        model_apply(1'b0, 16'h0005, '0);
        n_checks++; if (d !== TB_WS + 2) begin n_fail++; $display("[TB] FAIL rd_latency got=%0d want=%0d", d, TB_WS + 2); end
        n_checks++; if (r !== v) begin n_fail++; $display("[TB] FAIL rd_data got=%h want=%h", r, v); end
    endtask

    task automatic test_hold();
        int d, p; logic [127:0] r; logic [127:0] v;
        v = rand128();
        bus_txn(1'b1, 16'h0077, v, 5, d, p, r);
        model_apply(1'b1, 16'h0077, v);
        n_checks++; if (p !== 1) begin n_fail++; $display("[TB] FAIL hold_pulses got=%0d want=1", p); end
        n_checks++; if (stat_wr !== exp_stat(model_wr)) begin n_fail++; $display("[TB] FAIL hold_stat_wr got=%0d want=%0d", stat_wr, exp_stat(model_wr)); end
        bus_txn(1'b0, 16'h0077, '0, 0, d, p, r);
        model_apply(1'b0, 16'h0077, '0);
        n_checks++; if (r !== v) begin n_fail++; $display("[TB] FAIL hold_readback got=%h want=%h", r, v); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vals [2];
        logic [15:0]  adrs [2];
        int ack_cyc, prev;
        vals[0] = rand128(); vals[1] = rand128();
        adrs[0] = 16'h0021;  adrs[1] = 16'h0022;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            f_valid = 1'b1; f_we = (i < 2); f_addr = adrs[i % 2]; f_data = vals[i % 2];
            ack_cyc = -1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (f_ack) begin ack_cyc = cyc; break; end
            end
            if (i > 0) begin
                n_checks++;
                if (ack_cyc - prev !== 4) begin n_fail++; $display("[TB] FAIL b2b_gap[%0d] got=%0d want=4", i, ack_cyc - prev); end
            end
            if (i >= 2) begin
                n_checks++;
                if (f_rdata !== vals[i - 2]) begin n_fail++; $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", i, f_rdata, vals[i - 2]); end
            end
            prev = ack_cyc;
            f_valid = 1'b0;
            repeat (2) @(negedge clk);
        end
        n_checks++; if (f_swr !== exp_stat(2)) begin n_fail++; $display("[TB] FAIL b2b_stat_wr got=%0d want=%0d", f_swr, exp_stat(2)); end
        n_checks++; if (f_srd !== exp_stat(2)) begin n_fail++; $display("[TB] FAIL b2b_stat_rd got=%0d want=%0d", f_srd, exp_stat(2)); end
    endtask

    task automatic test_alias();
        int d, p; logic [127:0] r; logic [127:0] v;
        v = rand128();
        bus_txn(1'b1, 16'h0403, v, 0, d, p, r);
        model_apply(1'b1, 16'h0403, v);
        bus_txn(1'b0, 16'h0003, '0, 1, d, p, r);
        model_apply(1'b0, 16'h0003, '0);
        n_checks++; if (r !== v) begin n_fail++; $display("[TB] FAIL alias_data got=%h want=%h", r, v); end
    endtask

    task automatic test_reset_mid_request();
        int d, p; logic [127:0] r; logic [127:0] v;
        v = rand128() | 128'h1;
        bus_txn(1'b1, 16'h0010, v, 0, d, p, r);
        model_apply(1'b1, 16'h0010, v);
        bus_txn(1'b0, 16'h0010, '0, 0, d, p, r);
        model_apply(1'b0, 16'h0010, '0);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 16'h0010; bus_data = ~v;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ack got=%b want=0", ack); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("[TB] FAIL midrst_data got=%h want=0", rdata); end
        @(negedge clk);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ack_hold got=%b want=0", ack); end
        bus_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        bus_txn(1'b0, 16'h0010, '0, 0, d, p, r);
        model_apply(1'b0, 16'h0010, '0);
        n_checks++; if (r !== v) begin n_fail++; $display("[TB] FAIL midrst_uncommitted got=%h want=%h", r, v); end
        n_checks++; if (stat_rd !== exp_stat(1)) begin n_fail++; $display("[TB] FAIL midrst_stat_rd got=%0d want=%0d", stat_rd, exp_stat(1)); end
    endtask

    task automatic test_stats();
        int d, p; logic [127:0] r;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus_txn(1'b1, 16'(16'h0100 + i), rand128(), i, d, p, r);
        end
        for (int i = 0; i < 3; i++) begin
            bus_txn(1'b0, 16'(16'h0100 + (i % 2)), '0, 0, d, p, r);
        end
        n_checks++; if (stat_rd !== exp_stat(3)) begin n_fail++; $display("[TB] FAIL stats_rd got=%0d want=%0d", stat_rd, exp_stat(3)); end
        n_checks++; if (stat_wr !== exp_stat(2)) begin n_fail++; $display("[TB] FAIL stats_wr got=%0d want=%0d", stat_wr, exp_stat(2)); end
        model_mem.delete();
        model_rd = 3; model_wr = 2;
        model_last_rd = r;
    endtask

    task automatic test_random();
        int d, p; logic [127:0] r, v, exp_r;
        logic we; logic [15:0] addr;
        logic [15:0] written [$];
        for (int i = 0; i < 40; i++) begin
            we = (written.size() == 0) || 1'($urandom);
            v = rand128();
            if (we) begin
                addr = 16'($urandom);
                written.push_back(addr);
            end else begin
                addr = written[$urandom_range(0, written.size() - 1)];
                addr = {6'($urandom), addr[9:0]};
            end
            exp_r = we ? model_last_rd : model_mem[int'(addr[9:0])];
            bus_txn(we, addr, v, $urandom_range(0, 3), d, p, r);
            model_apply(we, addr, v);
            n_checks++; if (d !== TB_WS + 2) begin n_fail++; $display("[TB] FAIL rnd_latency[%0d] got=%0d want=%0d", i, d, TB_WS + 2); end
            n_checks++; if (p !== 1) begin n_fail++; $display("[TB] FAIL rnd_pulses[%0d] got=%0d want=1", i, p); end
            n_checks++; if (r !== exp_r) begin n_fail++; $display("[TB] FAIL rnd_data[%0d] we=%b addr=%h got=%h want=%h", i, we, addr, r, exp_r); end
        end
        n_checks++; if (stat_rd !== exp_stat(model_rd)) begin n_fail++; $display("[TB] FAIL rnd_stat_rd got=%0d want=%0d", stat_rd, exp_stat(model_rd)); end
        n_checks++; if (stat_wr !== exp_stat(model_wr)) begin n_fail++; $display("[TB] FAIL rnd_stat_wr got=%0d want=%0d", stat_wr, exp_stat(model_wr)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_back_to_back();
        test_alias();
        test_reset_mid_request();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
